// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Fetches are always full-word accesses.
    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : wait_timer
// Brief    : Clear/enable counter that flags the last allowed wait cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int             c_W        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_W-1:0] c_LAST_CNT = c_W'(TIMEOUT_CYCLES - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry always coincides with a clear from the owner, so no wrap is possible.
    assign o_expire = i_enable && (r_count == c_LAST_CNT);

endmodule : wait_timer
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Fixed-priority (data over fetch) sharing of one memory port,
//            single outstanding transaction, sticky timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [2:0]            dm_size,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  stall_if,
    output logic                  stall_dm,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    arb_state_t            r_state,     w_state_nxt;
    logic                  r_mem_req,   w_mem_req_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [2:0]            r_mem_size,  w_mem_size_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_dm_rdata,  w_dm_rdata_nxt;
    logic                  r_if_ready,  w_if_ready_nxt;
    logic                  r_dm_ready,  w_dm_ready_nxt;
    logic                  r_err,       w_err_nxt;
    logic                  w_if_pending, w_dm_pending;
    logic                  w_try_if, w_try_dm;
    logic                  w_busy, w_expire, w_timer_clear;

    // A request seen alongside its own ready pulse is the old one still held.
    assign w_if_pending = if_req & ~r_if_ready;
    assign w_dm_pending = dm_req & ~r_dm_ready;
    assign w_busy        = (r_state != IDLE);
    assign w_timer_clear = !w_busy || mem_ack || w_expire;

    wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_size  <= w_mem_size_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_dm_ready  <= w_dm_ready_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_size_nxt  = r_mem_size;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_ready_nxt  = 1'b0;
        w_dm_ready_nxt  = 1'b0;
        w_err_nxt       = r_err;
        w_try_if        = 1'b0;
        w_try_dm        = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_try_if = 1'b1;
                w_try_dm = 1'b1;
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    w_if_ready_nxt = 1'b1;
                    w_if_rdata_nxt = mem_rdata;
                    w_try_dm       = 1'b1;
                end else if (w_expire) begin
                    w_if_ready_nxt = 1'b1;
                    w_if_rdata_nxt = '0;
                    w_err_nxt      = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    w_dm_ready_nxt = 1'b1;
                    w_dm_rdata_nxt = r_mem_we ? '0 : mem_rdata;
                    w_try_if       = 1'b1;
                end else if (w_expire) begin
                    w_dm_ready_nxt = 1'b1;
                    w_dm_rdata_nxt = '0;
                    w_err_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_busy && (mem_ack || w_expire)) begin
            w_state_nxt   = IDLE;
            w_mem_req_nxt = 1'b0;
        end

        // A grant here overrides the drop above, giving bubble-free handover.
        if (w_try_dm && w_dm_pending) begin
            w_state_nxt     = BUSY_DM;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = dm_we;
            w_mem_size_nxt  = dm_size;
            w_mem_addr_nxt  = dm_addr;
            w_mem_wdata_nxt = dm_wdata;
        end else if (w_try_if && w_if_pending) begin
            w_state_nxt     = BUSY_IF;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_mem_size_nxt  = SIZE_WORD;
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
    assign stall_if  = w_if_pending;
    assign stall_dm  = w_dm_pending;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_size  = r_mem_size;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench: vector table, scoreboard on ready pulses,
//            plus contention, timeout, reset and ack/timeout-collision cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_TO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req, dm_req, dm_we, mem_ack;
    logic [c_AW-1:0] if_addr, dm_addr;
    logic [2:0]      dm_size;
    logic [c_DW-1:0] dm_wdata, mem_rdata;
    logic [c_DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic            if_ready, dm_ready, stall_if, stall_dm, mem_req, mem_we, err;
    logic [2:0]      mem_size;
    logic [c_AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata), .if_ready (if_ready),
        .dm_req (dm_req), .dm_we (dm_we), .dm_size (dm_size), .dm_addr (dm_addr),
        .dm_wdata (dm_wdata), .dm_rdata (dm_rdata), .dm_ready (dm_ready),
        .stall_if (stall_if), .stall_dm (stall_dm),
        .mem_req (mem_req), .mem_we (mem_we), .mem_size (mem_size), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_ack (mem_ack), .mem_rdata (mem_rdata), .err (err)
    );

    typedef struct {
        logic            is_dm;
        logic            we;
        logic [2:0]      size;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] wdata;
        int              delay;      // busy cycle in which memory acks
        logic [c_DW-1:0] mem_data;
        logic            exp_we;
        logic [2:0]      exp_size;
        logic [c_DW-1:0] exp_wdata;
        logic [c_DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic            is_dm;
        logic [c_DW-1:0] rdata;
    } sb_t;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_size = v.size; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        sb.push_back('{is_dm: v.is_dm, rdata: v.exp_rdata});
        tick();
        check("grant_mem_req",   32'(mem_req),   32'd1);
        check("grant_mem_addr",  mem_addr,       v.addr);
        check("grant_mem_we",    32'(mem_we),    32'(v.exp_we));
        check("grant_mem_size",  32'(mem_size),  32'(v.exp_size));
        check("grant_mem_wdata", mem_wdata,      v.exp_wdata);
        check("busy_stall",      32'(v.is_dm ? stall_dm : stall_if), 32'd1);
        repeat (v.delay - 1) tick();
        mem_ack = 1'b1; mem_rdata = v.mem_data;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("ready_pulse", 32'(v.is_dm ? dm_ready : if_ready), 32'd1);
        check("ready_stall", 32'(v.is_dm ? stall_dm : stall_if), 32'd0);
        check("done_mem_req", 32'(mem_req), 32'd0);
        if (v.is_dm) dm_req = 1'b0; else if_req = 1'b0;
        tick();
        check("ready_one_cycle", 32'(v.is_dm ? dm_ready : if_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_size = '0; dm_wdata = '0; mem_rdata = '0;

        //                 dm  we    size    addr          wdata         dly data          ewe   esize   ewdata        erdata
        vecs[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0,        3, 32'h0050_0093, 1'b0, 3'b010, 32'h0,        32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 3'b000, 32'h0000_0200, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1'b1, 3'b000, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h5555_5555, 2, 32'hCAFE_F00D, 1'b0, 3'b010, 32'h5555_5555, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 3'b000, 32'h0000_0014, 32'h0,        1, 32'h0000_0013, 1'b0, 3'b010, 32'h0,        32'h0000_0013};
        vecs[4] = '{1'b1, 1'b0, 3'b100, 32'h0000_0104, 32'h0,        4, 32'hA5A5_A5A5, 1'b0, 3'b100, 32'h0,        32'hA5A5_A5A5};
        vecs[5] = '{1'b0, 1'b0, 3'b000, 32'h0000_0018, 32'h0,        4, 32'h0000_1111, 1'b0, 3'b010, 32'h0,        32'h0000_1111};

        fork
            forever begin
                sb_t e;
                @(posedge clk);
                #1;
                if (if_ready || dm_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ready", 32'({if_ready, dm_ready}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_port",  32'(dm_ready), 32'(e.is_dm));
                        check("sb_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
                    end
                end
            end
        join_none

        #2;
        check("rst_mem_req",  32'(mem_req),  32'd0);
        check("rst_mem_addr", mem_addr,      32'd0);
        check("rst_ready",    32'({if_ready, dm_ready}), 32'd0);
        check("rst_err",      32'(err),      32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end
        check("collision_no_err", 32'(err), 32'd0);

        // Contention: data wins, fetch follows with no idle cycle in between.
        if_req = 1'b1; if_addr = 32'h0000_0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 3'b010; dm_addr = 32'h0000_0100;
        sb.push_back('{is_dm: 1'b1, rdata: 32'h0BAD_F00D});
        sb.push_back('{is_dm: 1'b0, rdata: 32'h0000_0073});
        tick();
        check("cont_first_addr", mem_addr, 32'h0000_0100);
        check("cont_if_stalled", 32'(stall_if), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check("cont_dm_ready",   32'(dm_ready), 32'd1);
        check("cont_no_bubble",  32'(mem_req),  32'd1);
        check("cont_if_addr",    mem_addr,      32'h0000_0040);
        check("cont_if_size",    32'(mem_size), 32'b010);
        dm_req = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0073;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("cont_if_ready", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        tick();

        // Timeout: fetch never acknowledged.
        if_req = 1'b1; if_addr = 32'h0000_0080;
        sb.push_back('{is_dm: 1'b0, rdata: 32'h0});
        tick();
        repeat (c_TO - 1) tick();
        check("to_not_yet", 32'(if_ready), 32'd0);
        check("to_err_not_yet", 32'(err), 32'd0);
        tick();
        check("to_ready", 32'(if_ready), 32'd1);
        check("to_err",   32'(err),      32'd1);
        check("to_drop",  32'(mem_req),  32'd0);
        if_req = 1'b0;
        tick();
        tick();
        check("to_err_sticky", 32'(err), 32'd1);
        run_txn('{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 2, 32'h7777_0001,
                  1'b0, 3'b010, 32'h0, 32'h7777_0001});
        check("to_err_still", 32'(err), 32'd1);

        // Reset during a data transaction; a late ack must be ignored.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400;
        tick();
        check("rm_busy", 32'(mem_req), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_mem_req", 32'(mem_req),  32'd0);
        check("rm_addr",    mem_addr,      32'd0);
        check("rm_err",     32'(err),      32'd0);
        dm_req = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("rm_late_ack_idle", 32'(mem_req), 32'd0);
        tick();
        check("rm_no_ready", 32'({if_ready, dm_ready}), 32'd0);
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
